// File: rtl/led_timer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_timer_ctrl: button-selected period timer with timeout pulse and LED.  |
// | Optional debounce stage: define LED_TIMER_CTRL_DEBOUNCE_EN.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module led_timer_ctrl #(
  parameter int unsigned SIM_DIVISOR     = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       button_i,
  input  logic       enable_i,
  output logic       timeout_o,
  output logic       led_o,
  output logic [2:0] freq_sel_o
);

  localparam logic [31:0] TIMER_FREQUENCY_100MHZ = 32'd500_000_000;
  localparam logic [31:0] TIMER_FREQUENCY_1HZ    = 32'd50_000_000;
  localparam logic [31:0] TIMER_FREQUENCY_2HZ    = 32'd25_000_000;
  localparam logic [31:0] TIMER_FREQUENCY_5HZ    = 32'd10_000_000;
  localparam logic [31:0] TIMER_FREQUENCY_10HZ   = 32'd5_000_000;

  function automatic logic [31:0] eff_count(input logic [31:0] period);
    logic [31:0] q;
    q = period / SIM_DIVISOR;
    return (q == 32'd0) ? 32'd1 : q;
  endfunction

  localparam logic [31:0] N_SLOW = eff_count(TIMER_FREQUENCY_100MHZ);
  localparam logic [31:0] N_1HZ  = eff_count(TIMER_FREQUENCY_1HZ);
  localparam logic [31:0] N_2HZ  = eff_count(TIMER_FREQUENCY_2HZ);
  localparam logic [31:0] N_5HZ  = eff_count(TIMER_FREQUENCY_5HZ);
  localparam logic [31:0] N_10HZ = eff_count(TIMER_FREQUENCY_10HZ);

  typedef enum logic [2:0] {
    FREQ_SLOW = 3'd0,
    FREQ_1HZ  = 3'd1,
    FREQ_2HZ  = 3'd2,
    FREQ_5HZ  = 3'd3,
    FREQ_10HZ = 3'd4
  } freq_state_t;

  logic        sync1_q, sync2_q, prev_q;
  logic        btn_level;
  logic        press;
  freq_state_t state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [31:0] period_n;
  logic        timeout_q, timeout_d;
  logic        led_q, led_d;

`ifdef LED_TIMER_CTRL_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;

  // Accepted level follows the synchronizer only after a full unbroken run of disagreement.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign btn_level = level_q;
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
  assign btn_level = sync2_q;
`endif

  assign press = btn_level & ~prev_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FREQ_SLOW: if (press) state_d = FREQ_1HZ;
      FREQ_1HZ:  if (press) state_d = FREQ_2HZ;
      FREQ_2HZ:  if (press) state_d = FREQ_5HZ;
      FREQ_5HZ:  if (press) state_d = FREQ_10HZ;
      FREQ_10HZ: if (press) state_d = FREQ_SLOW;
      default:   state_d = FREQ_1HZ;
    endcase
  end

  always_comb begin
    case (state_q)
      FREQ_SLOW: period_n = N_SLOW;
      FREQ_2HZ:  period_n = N_2HZ;
      FREQ_5HZ:  period_n = N_5HZ;
      FREQ_10HZ: period_n = N_10HZ;
      default:   period_n = N_1HZ;
    endcase
  end

  // A press outranks an expiry landing in the same cycle.
  always_comb begin
    count_d   = count_q;
    timeout_d = 1'b0;
    led_d     = led_q;
    if (!enable_i) begin
      count_d = '0;
      led_d   = 1'b0;
    end else if (press) begin
      count_d = '0;
    end else if (count_q >= period_n - 32'd1) begin
      count_d   = '0;
      timeout_d = 1'b1;
      led_d     = ~led_q;
    end else begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      state_q   <= FREQ_1HZ;
      count_q   <= '0;
      timeout_q <= 1'b0;
      led_q     <= 1'b0;
`ifdef LED_TIMER_CTRL_DEBOUNCE_EN
      level_q   <= 1'b0;
      db_cnt_q  <= '0;
`endif
    end else begin
      sync1_q   <= button_i;
      sync2_q   <= sync1_q;
      prev_q    <= btn_level;
      state_q   <= state_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      led_q     <= led_d;
`ifdef LED_TIMER_CTRL_DEBOUNCE_EN
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
`endif
    end
  end

  assign timeout_o  = timeout_q;
  assign led_o      = led_q;
  assign freq_sel_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_led_timer_ctrl.sv
`default_nettype none
// Bench for led_timer_ctrl: expected timeout pulses and frequency changes are queued
// ahead of time; a monitor pops and compares them as the DUT produces them.
module tb_led_timer_ctrl;

  localparam int unsigned SIM_DIV = 5000000;
  localparam int unsigned DB_CYC  = 4;
`ifdef LED_TIMER_CTRL_DEBOUNCE_EN
  localparam int PRESS_LAT = 3 + DB_CYC;
  localparam int PRESS_LEN = 10;
`else
  localparam int PRESS_LAT = 3;
  localparam int PRESS_LEN = 3;
`endif

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b1;
  logic       button_i = 1'b0;
  logic       enable_i = 1'b0;
  logic       timeout_o;
  logic       led_o;
  logic [2:0] freq_sel_o;

  typedef struct {
    int         edge_no;
    logic       led;
    logic [2:0] freq;
  } to_ev_t;

  typedef struct {
    int         edge_no;
    logic [2:0] freq;
  } fs_ev_t;

  to_ev_t to_q[$];
  fs_ev_t fs_q[$];
  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  led_timer_ctrl #(
    .SIM_DIVISOR    (SIM_DIV),
    .DEBOUNCE_CYCLES(DB_CYC)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .button_i  (button_i),
    .enable_i  (enable_i),
    .timeout_o (timeout_o),
    .led_o     (led_o),
    .freq_sel_o(freq_sel_o)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue num timeout pulses, one every period edges, the LED toggling from led_before.
  task automatic push_to(input int first, input int period, input int num,
                         input logic led_before, input logic [2:0] freq);
    logic led;
    led = led_before;
    for (int i = 0; i < num; i++) begin
      to_ev_t ev;
      led = ~led;
      ev.edge_no = first + i * period;
      ev.led     = led;
      ev.freq    = freq;
      to_q.push_back(ev);
    end
  endtask

  task automatic push_fs(input int e, input logic [2:0] freq);
    fs_ev_t ev;
    ev.edge_no = e;
    ev.freq    = freq;
    fs_q.push_back(ev);
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clock);
  endtask

  task automatic press_at(input int adv_edge, input int len);
    wait_until(adv_edge - PRESS_LAT);
    button_i = 1'b1;
    repeat (len) @(negedge clock);
    button_i = 1'b0;
  endtask

  initial begin : monitor
    logic [2:0] last_freq;
    to_ev_t     t;
    fs_ev_t     f;
    last_freq = 3'd1;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1) begin
        if (timeout_o === 1'b1) begin
          if (to_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_timeout: pulse at edge %0d, none expected", cyc);
          end else begin
            t = to_q.pop_front();
            check("timeout_edge", cyc, t.edge_no);
            check("timeout_led", {31'd0, led_o}, {31'd0, t.led});
            check("timeout_freq", {29'd0, freq_sel_o}, {29'd0, t.freq});
          end
        end
        if (freq_sel_o !== last_freq) begin
          if (fs_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_freq_change: got %0d at edge %0d, none expected", freq_sel_o, cyc);
          end else begin
            f = fs_q.pop_front();
            check("freq_change_edge", cyc, f.edge_no);
            check("freq_value", {29'd0, freq_sel_o}, {29'd0, f.freq});
          end
        end
      end
      last_freq = freq_sel_o;
    end
  end

  initial begin : stim
    int c, e1, e2, e3, e4, e5, e6, e7, r;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_freq_sel", {29'd0, freq_sel_o}, 32'd1);
    check("reset_timeout", {31'd0, timeout_o}, 32'd0);
    check("reset_led", {31'd0, led_o}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    c  = cyc;
    e1 = c + 48;
    e2 = e1 + 30;
    e3 = e2 + 30;
    e4 = e3 + 30;
    e5 = e4 + 110;
    e6 = e5 + 20;
    e7 = e6 + 15;

    push_to(c + 10, 10, 4, 1'b0, 3'd1);
    push_fs(e1, 3'd2);  push_to(e1 + 5, 5, 5, 1'b0, 3'd2);
    push_fs(e2, 3'd3);  push_to(e2 + 2, 2, 14, 1'b1, 3'd3);
    push_fs(e3, 3'd4);  push_to(e3 + 1, 1, 29, 1'b1, 3'd4);
    push_fs(e4, 3'd0);  push_to(e4 + 100, 100, 1, 1'b0, 3'd0);
    push_fs(e5, 3'd1);  push_to(e5 + 10, 10, 1, 1'b1, 3'd1);
    // e6 coincides with count = N-1 in 1 Hz: no pulse, LED holds 0.
    push_fs(e6, 3'd2);  push_to(e6 + 5, 5, 2, 1'b0, 3'd2);
    push_fs(e7, 3'd3);  push_to(e7 + 2, 2, 99, 1'b0, 3'd3);
    push_to(e7 + 206, 2, 3, 1'b0, 3'd3);

    enable_i = 1'b1;
    press_at(e1, PRESS_LEN);
    press_at(e2, PRESS_LEN);
    press_at(e3, PRESS_LEN);
    press_at(e4, PRESS_LEN);
    press_at(e5, PRESS_LEN);
    press_at(e6, PRESS_LEN);
    press_at(e7, 200);

    wait_until(e7 + 199);
    check("led_before_disable", {31'd0, led_o}, 32'd1);
    enable_i = 1'b0;
    @(negedge clock);
    check("led_disabled", {31'd0, led_o}, 32'd0);
    check("timeout_disabled", {31'd0, timeout_o}, 32'd0);
    wait_until(e7 + 204);
    enable_i = 1'b1;

    wait_until(e7 + 211);
    #1 reset_n = 1'b0;
    button_i = 1'b1;
    #1;
    check("async_reset_freq_sel", {29'd0, freq_sel_o}, 32'd1);
    check("async_reset_led", {31'd0, led_o}, 32'd0);
    check("async_reset_timeout", {31'd0, timeout_o}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    r = cyc;
    push_fs(r + PRESS_LAT, 3'd2);
    push_to(r + PRESS_LAT + 5, 5, 4, 1'b0, 3'd2);
    wait_until(r + PRESS_LAT + 2);
    button_i = 1'b0;
`ifdef LED_TIMER_CTRL_DEBOUNCE_EN
    wait_until(r + PRESS_LAT + 10);
    button_i = 1'b1;
    repeat (3) @(negedge clock);
    button_i = 1'b0;
`endif
    wait_until(r + PRESS_LAT + 24);
    check("timeout_queue_drained", to_q.size(), 32'd0);
    check("freq_queue_drained", fs_q.size(), 32'd0);
    check("final_freq_sel", {29'd0, freq_sel_o}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    repeat (3000) @(posedge clock);
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: stimulus stuck at edge %0d, limit 3000", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
